gray_pattern_checker: RTL and testbench

Synthesizable self-checking stimulus/response block for the two-input gate lab designs. It drives `a`/`b` through the Gray sweep 00→01→11→10 and holds each vector for a programmable settle window. It then samples the DUT output `y`, compares it against a parameterized truth table, and reports an error count and a pass flag. It sits on the board side of the two-input gate DUT and closes the loop that the simulation bench leaves open.

---
 rtl/gray_pattern_checker_pkg.sv | 16 +
 rtl/gray_pattern_checker_settle_timer.sv | 26 ++
 rtl/gray_pattern_checker.sv | 132 +++++++++++++
 tb/tb_gray_pattern_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pattern_checker_pkg.sv
// Shared types and constants for the gray-sweep gate checker.
// GRAY_SEQ is the stimulus order; a single bit changes between neighbours, including the wrap.
package checker_pkg;

    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } chk_state_t;

    localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

endpackage

// File: rtl/gray_pattern_checker_settle_timer.sv
// Loadable down-counter that holds at zero; zero flags the end of a settle window.
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gray_pattern_checker.sv
// Board-side checker for two-input gate labs: sweeps a/b in Gray order, samples y after a
// settle window, compares against EXPECT and reports error count, last failing vector and pass.
module gray_pattern_checker
    import checker_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] EXPECT        = 4'b0110,
    parameter int         NUM_PASSES    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       last_fail_vec
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);

    chk_state_t  state;
    chk_state_t  state_next;
    logic [1:0]  vec_idx;
    logic [3:0]  pass_cnt;
    logic [1:0]  ab;
    logic        timer_load;
    logic        timer_zero;
    logic        accept;
    logic        do_check;
    logic        finish;
    logic        mismatch;

    settle_timer #(
        .W(8)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        accept     = 1'b0;
        do_check   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                do_check = 1'b1;
                if (vec_idx == 2'd3 && pass_cnt == LAST_PASS) begin
                    state_next = DONE;
                end else begin
                    timer_load = 1'b1;
                    state_next = SETTLE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mismatch = (y != EXPECT[ab]);

    // The final CHECK also advances to index 0, so a/b are already back at 00 during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab            <= 2'b00;
            vec_idx       <= 2'd0;
            pass_cnt      <= 4'd0;
            err_count     <= '0;
            last_fail_vec <= 2'b00;
            pass          <= 1'b0;
        end else if (accept) begin
            ab            <= GRAY_SEQ[0];
            vec_idx       <= 2'd0;
            pass_cnt      <= 4'd0;
            err_count     <= '0;
            last_fail_vec <= 2'b00;
            pass          <= 1'b0;
        end else if (do_check) begin
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                last_fail_vec <= ab;
            end
            if (vec_idx == 2'd3) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
            vec_idx <= vec_idx + 2'd1;
            ab      <= GRAY_SEQ[vec_idx + 2'd1];
        end else if (finish) begin
            pass <= (err_count == '0);
        end
    end

    assign a    = ab[1];
    assign b    = ab[0];
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gray_pattern_checker.sv
// Directed bench: three checker configurations driven by a modelled gate DUT (xor/0/1/xnor).
module tb_gray_pattern_checker;

    typedef struct {
        int         idx;
        logic [1:0] mode;
        int         exp_len;
        int         exp_err;
        logic [1:0] exp_lfv;
        logic       exp_pass;
    } vec_t;

    localparam int         SET [3]   = '{4, 4, 1};
    localparam int         PAS [3]   = '{1, 3, 15};
    localparam logic [1:0] SWEEP [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v [3];
    logic [1:0] mode_v [3];
    logic       y_v [3];
    logic       a_v [3];
    logic       b_v [3];
    logic       busy_v [3];
    logic       done_v [3];
    logic       pass_v [3];
    logic [7:0] err_v [3];
    logic [1:0] lfv_v [3];

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    // Gate model: 0 = xor, 1 = stuck-at-0, 2 = stuck-at-1, 3 = xnor.
    function automatic logic model_y(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a ^ b;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            y_v[i] = model_y(mode_v[i], a_v[i], b_v[i]);
        end
    end

    gray_pattern_checker #(.SETTLE_CYCLES(4), .EXPECT(4'b0110), .NUM_PASSES(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .y(y_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .last_fail_vec(lfv_v[0])
    );

    gray_pattern_checker #(.SETTLE_CYCLES(4), .EXPECT(4'b0110), .NUM_PASSES(3)) dut_m (
        .clk(clk), .reset(reset), .start(start_v[1]), .y(y_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .last_fail_vec(lfv_v[1])
    );

    gray_pattern_checker #(.SETTLE_CYCLES(1), .EXPECT(4'b1111), .NUM_PASSES(15)) dut_s (
        .clk(clk), .reset(reset), .start(start_v[2]), .y(y_v[2]), .a(a_v[2]), .b(b_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
        .last_fail_vec(lfv_v[2])
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] packed_outs(input int idx);
        return {a_v[idx], b_v[idx], busy_v[idx], done_v[idx], pass_v[idx], err_v[idx], lfv_v[idx]};
    endfunction

    task automatic accept_start(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    // Call just after the accepting edge; counts edges until done and checks the sweep.
    task automatic wait_done(input int idx, output int len, output int seq_bad);
        int limit;
        logic [1:0] want;
        limit   = 4 * PAS[idx] * (SET[idx] + 1) + 40;
        len     = 0;
        seq_bad = 0;
        while (1) begin
            @(negedge clk);
            if (done_v[idx] === 1'b1 || len >= limit) break;
            want = SWEEP[(len / (SET[idx] + 1)) % 4];
            if ({a_v[idx], b_v[idx]} !== want || busy_v[idx] !== 1'b1) seq_bad++;
            @(posedge clk);
            len++;
        end
    endtask

    task automatic finish_checks(input string tag, input vec_t v, input int len, input int bad);
        check_output({tag, "_len"}, len, v.exp_len);
        check_output({tag, "_sweep"}, bad, 0);
        check_output({tag, "_done_cycle"}, {done_v[v.idx], busy_v[v.idx], a_v[v.idx], b_v[v.idx]},
                     4'b1000);
        @(posedge clk);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, done_v[v.idx], 1'b0);
        check_output({tag, "_err"}, err_v[v.idx], v.exp_err);
        check_output({tag, "_lfv"}, lfv_v[v.idx], v.exp_lfv);
        check_output({tag, "_pass"}, pass_v[v.idx], v.exp_pass);
        repeat (3) @(negedge clk);
        check_output({tag, "_pass_hold"}, pass_v[v.idx], v.exp_pass);
    endtask

    task automatic apply_stimulus(input string tag, input vec_t v);
        int len;
        int bad;
        mode_v[v.idx] = v.mode;
        accept_start(v.idx);
        wait_done(v.idx, len, bad);
        finish_checks(tag, v, len, bad);
    endtask

    initial begin
        int len;
        int bad;
        vec_t v;

        vecs[0] = '{idx: 0, mode: 2'd0, exp_len: 20,  exp_err: 0,  exp_lfv: 2'b00, exp_pass: 1'b1};
        vecs[1] = '{idx: 0, mode: 2'd1, exp_len: 20,  exp_err: 2,  exp_lfv: 2'b10, exp_pass: 1'b0};
        vecs[2] = '{idx: 0, mode: 2'd2, exp_len: 20,  exp_err: 2,  exp_lfv: 2'b11, exp_pass: 1'b0};
        vecs[3] = '{idx: 0, mode: 2'd3, exp_len: 20,  exp_err: 4,  exp_lfv: 2'b10, exp_pass: 1'b0};
        vecs[4] = '{idx: 1, mode: 2'd2, exp_len: 60,  exp_err: 6,  exp_lfv: 2'b11, exp_pass: 1'b0};
        vecs[5] = '{idx: 1, mode: 2'd0, exp_len: 60,  exp_err: 0,  exp_lfv: 2'b00, exp_pass: 1'b1};
        vecs[6] = '{idx: 2, mode: 2'd1, exp_len: 120, exp_err: 60, exp_lfv: 2'b10, exp_pass: 1'b0};
        vecs[7] = '{idx: 2, mode: 2'd2, exp_len: 120, exp_err: 0,  exp_lfv: 2'b00, exp_pass: 1'b1};

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 2'd0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_state_%0d", i), packed_outs(i), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during the second settle window, after one mismatch was already recorded.
        mode_v[0] = 2'd3;
        accept_start(0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_output("midrun_err_before_reset", err_v[0], 8'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("midrun_reset_outputs", packed_outs(0), 32'd0);
        reset = 1'b0;
        v = vecs[0];
        apply_stimulus("after_reset", v);

        // start held high through a whole run: next run is accepted in the IDLE after DONE.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, len, bad);
        check_output("held_len", len, 20);
        check_output("held_sweep", bad, 0);
        check_output("held_done", done_v[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_output("held_idle", {busy_v[0], done_v[0], pass_v[0]}, 3'b001);
        @(posedge clk);
        @(negedge clk);
        check_output("held_reaccept", {busy_v[0], pass_v[0]}, 2'b10);
        start_v[0] = 1'b0;
        len = 0;
        while (done_v[0] !== 1'b1 && len < 60) begin
            @(posedge clk);
            len++;
            @(negedge clk);
        end
        check_output("held_second_len", len, 20);
        @(posedge clk);
        @(negedge clk);
        check_output("held_second_pass", pass_v[0], 1'b1);

        // Saturation: preload 250 before the first check of a 60-mismatch run.
        mode_v[2] = 2'd1;
        accept_start(2);
        force dut_s.err_count = 8'd250;
        #2;
        release dut_s.err_count;
        wait_done(2, len, bad);
        v = '{idx: 2, mode: 2'd1, exp_len: 120, exp_err: 255, exp_lfv: 2'b10, exp_pass: 1'b0};
        finish_checks("saturate", v, len, bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
